// File: rtl/uart_status_tx.sv
// Status-byte UART transmitter for the player-to-player link: tagged, parity-protected 8N1 frames
// on status change or keepalive. Define UART_STATUS_TX_DOUBLE_STOP_EN for two stop bits (8N2).
module uart_status_tx #(
  parameter int BAUD_DIV         = 6771,
  parameter int KEEPALIVE_CYCLES = 6500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_over,
  input  logic       player_ready,
  input  logic       play_selected,
  input  logic       multiplayer,
  output logic       tx,
  output logic       busy,
  output logic       frame_sent,
  output logic [7:0] last_frame
);

`ifdef UART_STATUS_TX_DOUBLE_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int KA_W   = (KEEPALIVE_CYCLES > 2) ? $clog2(KEEPALIVE_CYCLES) : 1;
  localparam logic [2:0] SYNC_TAG = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state_reg;
  logic [BAUD_W-1:0] baud_cnt_reg;
  logic [2:0]        bit_idx_reg;
  logic [KA_W-1:0]   ka_cnt_reg;
  logic [3:0]        snapshot_reg;
  logic              pending_reg;
  logic [7:0]        shift_reg;

  logic [3:0]        status_now;
  logic [7:0]        frame_byte;
  logic              status_changed;
  logic              baud_last;
  logic [2:0]        bit_idx_inc;
  logic [KA_W-1:0]   ka_cnt_inc;
  logic              ka_expire;

  assign status_now     = {multiplayer, play_selected, player_ready, game_over};
  assign frame_byte     = {SYNC_TAG, status_now, ^{SYNC_TAG, status_now}};
  assign status_changed = (status_now != snapshot_reg);
  assign baud_last      = (baud_cnt_reg == BAUD_W'(BAUD_DIV - 1));
  assign bit_idx_inc    = bit_idx_reg + 3'd1;
  assign ka_cnt_inc     = ka_cnt_reg + KA_W'(1);
  // Fire on the increment that would reach KEEPALIVE_CYCLES-1, so the line idles exactly
  // KEEPALIVE_CYCLES cycles between the stop bit and the next start bit.
  assign ka_expire      = (ka_cnt_inc == KA_W'(KEEPALIVE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      ka_cnt_reg   <= '0;
      snapshot_reg <= 4'b0000;
      pending_reg  <= 1'b1;
      shift_reg    <= 8'h00;
      tx           <= 1'b1;
      busy         <= 1'b0;
      frame_sent   <= 1'b0;
      last_frame   <= 8'h00;
    end else begin
      frame_sent <= 1'b0;
      if (status_changed) begin
        pending_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          tx <= 1'b1;
          if (pending_reg) begin
            // Load clears pending; the snapshot takes the same inputs, so it is never stale here.
            snapshot_reg <= status_now;
            shift_reg    <= frame_byte;
            last_frame   <= frame_byte;
            pending_reg  <= 1'b0;
            ka_cnt_reg   <= '0;
            baud_cnt_reg <= '0;
            busy         <= 1'b1;
            tx           <= 1'b0;
            state_reg    <= START;
          end else if (ka_expire) begin
            pending_reg <= 1'b1;
            ka_cnt_reg  <= '0;
          end else begin
            ka_cnt_reg <= ka_cnt_inc;
          end
        end

        START: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= 3'd0;
            tx           <= shift_reg[0];
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              bit_idx_reg <= 3'd0;
              tx          <= 1'b1;
              state_reg   <= STOP;
            end else begin
              bit_idx_reg <= bit_idx_inc;
              tx          <= shift_reg[bit_idx_inc];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
          end
        end

        STOP: begin
          tx <= 1'b1;
          // bit_idx_reg is reused to count stop bits.
          if (baud_last) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 3'(STOP_BITS - 1)) begin
              bit_idx_reg <= 3'd0;
              frame_sent  <= 1'b1;
              busy        <= 1'b0;
              state_reg   <= IDLE;
            end else begin
              bit_idx_reg <= bit_idx_inc;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
          tx        <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
